// File: rtl/icache_param_if.sv
// icache_param_if: bundles the two instruction channels of the cache.
//   Datapath side : imemREN, imemaddr (requests)  -> ihit, imemload (responses)
//                   iinv (invalidate all blocks)
//   Memory side   : iREN, iaddr (word read request) <- iwait, iload (stall, data)
// The cache connects through the slave modport; the environment (datapath and
// memory together) uses the master modport.
interface icache_param_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iinv;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iinv, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iinv, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_param.sv
// icache_param: direct-mapped, read-only instruction cache with block fill.
//   CLK, nRST          : clock (rising edge), asynchronous active-low reset
//   bus (slave)        : datapath request/response and memory fill channel
//   hit_cnt, miss_cnt  : wrapping performance counters, cleared only by reset
// Hits answer combinationally in IDLE. A miss latches the block address and
// fetches BLOCK_WORDS words in ascending order; the set becomes valid only
// after the last word is written. iinv clears every valid bit and aborts a
// fill in progress.
//
// state | meaning
// IDLE  | lookup; hit answers this cycle, miss latches block and starts fill
// FILL  | iREN high, one word per accepted beat, validate after last word
module icache_param #(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  icache_param_if.slave    bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WORD_BITS = $clog2(BLOCK_WORDS);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int TAG_LSB   = 2 + WORD_BITS + IDX_BITS;
  localparam int TAG_BITS  = 32 - TAG_LSB;
  // Fill counter keeps at least one bit so single-word blocks still elaborate.
  localparam int CW        = (WORD_BITS > 0) ? WORD_BITS : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic [SETS-1:0]     valid;
  logic [TAG_BITS-1:0] tag_mem  [SETS];
  logic [31:0]         data_mem [SETS][BLOCK_WORDS];

  logic [TAG_BITS-1:0] fill_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [CW-1:0]       fill_cnt;
  logic                iren_q;
  logic [31:0]         iaddr_q;

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic [CW-1:0]       req_word;
  logic [1:0]          unused_offset;
  logic                lookup_hit;
  logic                hit_now;
  logic                miss_now;
  logic                beat;
  logic                last_word;

  assign req_tag       = bus.imemaddr[31:TAG_LSB];
  assign req_idx       = bus.imemaddr[TAG_LSB-1:TAG_LSB-IDX_BITS];
  assign unused_offset = bus.imemaddr[1:0];

  if (WORD_BITS > 0) begin : g_word
    assign req_word = bus.imemaddr[2 +: WORD_BITS];
  end else begin : g_noword
    assign req_word = '0;
  end

  function automatic logic [31:0] block_addr(input logic [TAG_BITS-1:0] t,
                                             input logic [IDX_BITS-1:0] i,
                                             input logic [CW-1:0]       w);
    logic [31:0] a;
    a = '0;
    a[31:TAG_LSB]                  = t;
    a[TAG_LSB-1:TAG_LSB-IDX_BITS]  = i;
    if (WORD_BITS > 0) a[2 +: CW]  = w;
    return a;
  endfunction

  // Tag array is never reset; valid gates the compare so stale tags never hit.
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_now    = (state == IDLE) && bus.imemREN && !bus.iinv && lookup_hit;
  assign miss_now   = (state == IDLE) && bus.imemREN && !bus.iinv && !lookup_hit;
  assign beat       = (state == FILL) && !bus.iwait && !bus.iinv;
  assign last_word  = (fill_cnt == CW'(BLOCK_WORDS - 1));

  assign bus.ihit     = hit_now;
  assign bus.imemload = hit_now ? data_mem[req_idx][req_word] : 32'h0;
  assign bus.iREN     = iren_q;
  assign bus.iaddr    = iaddr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      valid    <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      fill_cnt <= '0;
      iren_q   <= 1'b0;
      iaddr_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_now) hit_cnt <= hit_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (bus.iinv) begin
            valid <= '0;
          end else if (miss_now) begin
            fill_tag         <= req_tag;
            fill_idx         <= req_idx;
            fill_cnt         <= '0;
            // The set is overwritten word by word, so its old contents stop
            // being trustworthy as soon as the fill starts.
            valid[req_idx]   <= 1'b0;
            miss_cnt         <= miss_cnt + 1'b1;
            iren_q           <= 1'b1;
            iaddr_q          <= block_addr(req_tag, req_idx, '0);
            state            <= FILL;
          end
        end
        FILL: begin
          if (bus.iinv) begin
            valid    <= '0;
            fill_cnt <= '0;
            iren_q   <= 1'b0;
            iaddr_q  <= '0;
            state    <= IDLE;
          end else if (!bus.iwait) begin
            if (last_word) begin
              valid[fill_idx] <= 1'b1;
              fill_cnt        <= '0;
              iren_q          <= 1'b0;
              iaddr_q         <= '0;
              state           <= IDLE;
            end else begin
              fill_cnt <= CW'(fill_cnt + 1'b1);
              iaddr_q  <= block_addr(fill_tag, fill_idx, CW'(fill_cnt + 1'b1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked solely by valid[].
  always_ff @(posedge CLK) begin
    if (beat) begin
      data_mem[fill_idx][fill_cnt] <= bus.iload;
      if (last_word) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: directed scoreboard bench for icache_param (default params).
// Requests push their expected word into a hit queue and every expected memory
// beat into a beat queue; independent monitors pop and compare whenever the
// DUT presents ihit or an accepted memory beat.
module tb_icache_param;
  logic        CLK;
  logic        nRST;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  icache_param_if bus();

  icache_param #(.SETS(16), .BLOCK_WORDS(2), .CNT_W(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int lat      = 0;   // extra iwait cycles per memory word
  int beat_age = 0;
  int run      = 0;

  logic [31:0] exp_hit_addr[$];
  logic [31:0] exp_hit_data[$];
  logic [31:0] exp_beat_addr[$];
  int          exp_beat_cyc[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA0001;
    if (a == 32'h44) return 32'hAAAA0002;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Memory model: each word is stalled for `lat` cycles, then accepted.
  always @(posedge CLK) begin
    if (bus.iREN && !bus.iwait) beat_age = 0;
    else if (bus.iREN)          beat_age++;
    else                        beat_age = 0;
    #1;
    bus.iwait = bus.iREN && (beat_age < lat);
    bus.iload = mem_word(bus.iaddr);
  end

  // Hit monitor.
  always @(negedge CLK) begin
    if (nRST && bus.ihit) begin
      if (exp_hit_addr.size() == 0) begin
        check("unexpected_hit", 32'h1, 32'h0);
      end else begin
        check("hit_addr", bus.imemaddr, exp_hit_addr.pop_front());
        check("hit_data", bus.imemload, exp_hit_data.pop_front());
      end
    end
  end

  // Memory beat monitor: address of each accepted beat and how long it was held.
  always @(negedge CLK) begin
    if (nRST && bus.iREN) begin
      run++;
      if (!bus.iwait) begin
        if (exp_beat_addr.size() == 0) begin
          check("unexpected_beat", bus.iaddr, 32'hFFFFFFFF);
        end else begin
          check("beat_addr", bus.iaddr, exp_beat_addr.pop_front());
          check("beat_hold", run, exp_beat_cyc.pop_front());
        end
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  task automatic expect_fill(input logic [31:0] base, input int cyc);
    exp_beat_addr.push_back(base);
    exp_beat_cyc.push_back(cyc);
    exp_beat_addr.push_back(base + 32'h4);
    exp_beat_cyc.push_back(cyc);
  endtask

  // Drive a request until it hits; exp_lat < 0 skips the latency check.
  task automatic request(input logic [31:0] addr, input logic [31:0] data, input int exp_lat);
    int n;
    bit got;
    exp_hit_addr.push_back(addr);
    exp_hit_data.push_back(data);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge CLK);
      if (bus.ihit) got = 1'b1;
      else begin
        @(posedge CLK); #1;
        n++;
      end
    end
    check("hit_timeout", {31'h0, got}, 32'h1);
    if (exp_lat >= 0) check("hit_latency", n, exp_lat);
    @(posedge CLK); #1;
    bus.imemREN = 1'b0;
  endtask

  task automatic do_reset();
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iinv     = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ihit", {31'h0, bus.ihit}, 32'h0);
    check("rst_iren", {31'h0, bus.iREN}, 32'h0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    check("rst_imemload", bus.imemload, 32'h0);
    check("rst_hit_cnt", {16'h0, hit_cnt}, 32'h0);
    check("rst_miss_cnt", {16'h0, miss_cnt}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bus.iwait = 1'b0;
    bus.iload = '0;
    do_reset();

    // 1: zero-wait fill of 0x40, then neighbouring word hits at once.
    lat = 0;
    expect_fill(32'h40, 1);
    request(32'h40, 32'hAAAA0001, 3);   // hit in the 4th cycle of the request
    request(32'h44, 32'hAAAA0002, 0);
    check("t1_miss_cnt", {16'h0, miss_cnt}, 32'd1);
    check("t1_hit_cnt", {16'h0, hit_cnt}, 32'd2);

    // 2: three stall cycles per word: each address held 4 cycles.
    do_reset();
    lat = 3;
    expect_fill(32'h40, 4);
    request(32'h40, 32'hAAAA0001, 9);
    check("t2_miss_cnt", {16'h0, miss_cnt}, 32'd1);
    check("t2_hit_cnt", {16'h0, hit_cnt}, 32'd1);

    // 3: aliasing on index 8.
    lat = 0;
    request(32'h40, 32'hAAAA0001, 0);
    expect_fill(32'h840, 1);
    request(32'h840, 32'hC0DE0840, 3);
    expect_fill(32'h40, 1);
    request(32'h40, 32'hAAAA0001, 3);
    check("t3_miss_cnt", {16'h0, miss_cnt}, 32'd3);
    check("t3_hit_cnt", {16'h0, hit_cnt}, 32'd4);

    // 4a: invalidate a warm block.
    expect_fill(32'h80, 1);
    request(32'h80, 32'hC0DE0080, 3);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    bus.iinv     = 1'b1;
    @(negedge CLK);
    check("inv_ihit", {31'h0, bus.ihit}, 32'h0);
    @(posedge CLK); #1;
    bus.iinv = 1'b0;
    expect_fill(32'h80, 1);
    request(32'h80, 32'hC0DE0080, -1);
    check("t4_miss_cnt", {16'h0, miss_cnt}, 32'd5);
    check("t4_hit_cnt", {16'h0, hit_cnt}, 32'd6);

    // 4b: invalidate during a stalled fill; the block must not become valid.
    lat = 3;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h200;
    @(posedge CLK); #1;
    check("abort_fill_started", {31'h0, bus.iREN}, 32'h1);
    @(posedge CLK); #1;
    bus.iinv    = 1'b1;
    bus.imemREN = 1'b0;
    @(posedge CLK); #1;
    bus.iinv = 1'b0;
    @(negedge CLK);
    check("abort_iren", {31'h0, bus.iREN}, 32'h0);
    @(posedge CLK); #1;
    lat = 0;
    expect_fill(32'h200, 1);
    request(32'h200, 32'hC0DE0200, 3);
    check("t4b_miss_cnt", {16'h0, miss_cnt}, 32'd7);

    // 5: address changes mid-fill; old block still installs.
    expect_fill(32'hC0, 1);
    expect_fill(32'h100, 1);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'hC0;
    @(posedge CLK); #1;
    check("t5_fill_started", {31'h0, bus.iREN}, 32'h1);
    request(32'h100, 32'hC0DE0100, -1);
    request(32'hC0, 32'hC0DE00C0, 0);
    request(32'hC4, 32'hC0DE00C4, 0);
    check("t5_miss_cnt", {16'h0, miss_cnt}, 32'd9);
    check("t5_hit_cnt", {16'h0, hit_cnt}, 32'd10);

    // 6: asynchronous reset during a fill.
    lat = 3;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h300;
    @(posedge CLK); #1;
    check("t6_fill_started", {31'h0, bus.iREN}, 32'h1);
    #3;
    nRST        = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    check("t6_rst_iren", {31'h0, bus.iREN}, 32'h0);
    check("t6_rst_ihit", {31'h0, bus.ihit}, 32'h0);
    check("t6_rst_hit_cnt", {16'h0, hit_cnt}, 32'h0);
    check("t6_rst_miss_cnt", {16'h0, miss_cnt}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    lat = 0;
    expect_fill(32'hC0, 1);
    request(32'hC0, 32'hC0DE00C0, 3);
    check("t6_miss_cnt", {16'h0, miss_cnt}, 32'd1);
    check("t6_hit_cnt", {16'h0, hit_cnt}, 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    check("hit_queue_drained", exp_hit_addr.size(), 32'd0);
    check("beat_queue_drained", exp_beat_addr.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_param.md
Name: icache_param

Overview:
- Parametrised, direct-mapped, read-only instruction cache.
- Sits between the datapath instruction port (imemREN/imemaddr/ihit/imemload) and the memory-side instruction channel (iREN/iaddr/iwait/iload).
- Replaces the single-cycle pass-through path: hits return in the same cycle; misses run a multi-word block-fill state machine.
- Provides a synchronous invalidate input and hit/miss performance counters.

Parameters:
- SETS, 16, number of sets; power of two, ≥2.
- BLOCK_WORDS, 2, 32-bit words per block; power of two, ≥1.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; valid when ihit=1.
- iinv  in  1  synchronous invalidate of all blocks.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, word aligned.
- iwait  in  1  memory stall; data is accepted when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_cnt  out  CNT_W  count of hits.
- miss_cnt  out  CNT_W  count of misses.

Behaviour:
- Address split: offset = imemaddr[1:0]; word = next log2(BLOCK_WORDS) bits; index = next log2(SETS) bits; tag = the remaining upper bits. Defaults give 1 word bit, 4 index bits and 25 tag bits.
- Storage per set: valid bit, tag, BLOCK_WORDS data words. No dirty state.
- Reset (asynchronous):
  - All valid bits = 0; state = IDLE; fill counter = 0; hit_cnt = 0; miss_cnt = 0.
  - Outputs: ihit = 0, iREN = 0, iaddr = 0, imemload = 0.
  - Data and tag arrays are not reset.
- States:
  - IDLE: ihit = imemREN & valid[index] & (tag == stored tag). imemload = stored word when ihit, else 0. Combinational, zero latency.
    - On a hit, hit_cnt increments at the clock edge.
    - On imemREN & !hit: latch tag/index into the fill register, fill counter = 0, miss_cnt increments, go to FILL. The miss cycle itself has ihit = 0 and iREN = 0.
  - FILL: iREN = 1; iaddr = {latched tag, latched index, fill counter, 2'b00}; ihit = 0.
    - On iwait = 0: write iload into word[fill counter] of the latched set; increment the fill counter.
    - When the last word is written: set valid, write the tag, return to IDLE.
    - While iwait = 1: hold iaddr and the fill counter stable.
  - IDLE after a fill: the original request (if still asserted with the same address) hits next cycle. Miss penalty = 1 + BLOCK_WORDS × (memory latency) + 1 cycles.
- Fill words are fetched in ascending order from word 0. No critical-word-first.
- imemREN deasserted or imemaddr changed during FILL: the fill completes on the latched address and the block is installed. The new address is evaluated in IDLE.
- iinv:
  - In IDLE: all valid bits clear at the edge; ihit is forced 0 in the same cycle iinv = 1.
  - In FILL: the fill aborts, the partial block is not validated, and the FSM returns to IDLE.
  - iinv has priority over fill completion in the same cycle.
- Counters wrap modulo 2^CNT_W and are cleared only by reset, not by iinv.
- Counting rule: a miss counts once, when it is detected. The eventual hit of the same request also counts as a hit.
- Aliasing: two addresses with the same index and different tags evict each other. A fill always overwrites the whole set.
- No X on outputs after reset, regardless of array contents.

Test Plan:
1. Reset, then imemREN = 1, imemaddr = 0x00000040, memory returns 0xAAAA0001/0xAAAA0002 with iwait = 0. Required response:
   - iaddr = 0x40, then 0x44.
   - ihit rises 4 cycles after the request with imemload = 0xAAAA0001.
   - imemaddr = 0x44 then hits immediately with 0xAAAA0002.
   - miss_cnt = 1, hit_cnt = 2.
2. Same as 1 but iwait = 1 for 3 cycles per word. Required response: iaddr holds 0x40 for 4 cycles, then 0x44 for 4 cycles; ihit only after both words are written.
3. Fill 0x00000040, then request 0x00000840 (same index, different tag). Required response: a miss and a refill at 0x840/0x844. A later request to 0x40 misses again; miss_cnt = 3.
4. Warm 0x80, pulse iinv for one cycle, re-request 0x80. Required response: ihit = 0 on the iinv cycle and the request misses again. Then assert iinv in the middle of a fill: no validation, and the FSM returns to IDLE.
5. Start a miss at 0xC0, switch imemaddr to 0x100 mid-fill. Required response: the 0xC0 block fills and becomes valid, then 0x100 misses and fills.
6. Assert nRST = 0 during FILL. Required response: iREN, ihit and the counters go to 0 immediately. After release, the previously filled block misses.
